framebuffer_page_ctrl: RTL
==========================

# framebuffer_page_ctrl

Double-buffer (page-flip) controller and port-A arbiter for the framebuffer RAM. It sits between `control_module`/`framebuffer_fetch` and a `multimem` instance of twice the depth. Host writes always land in the back page, and the scan fetch always reads the front page. Page swaps occur only at a frame boundary, so no frame ever shows a half-written image. A background clear engine fills the back page with a constant, using idle port-A cycles.

## Interface
Parameters:
- `ADDR_A_WIDTH`, 12: host byte-address width; one page holds 2^12 bytes.
- `ADDR_B_WIDTH`, 11: fetch word-address width; one page holds 2^11 16-bit words.
- `SWAP_COUNT_WIDTH`, 8: width of the swap counter.

Ports:
- `clk_in`, in, 1: the single clock (clk_root domain).
- `reset`, in, 1: asynchronous, active-low.
- `host_address`, in, ADDR_A_WIDTH: write address from `control_module`.
- `host_data`, in, 8: write data.
- `host_write_enable`, in, 1: write strobe.
- `host_clk_enable`, in, 1: port-A enable from the host.
- `swap_request`, in, 1: one-cycle pulse requesting a page flip.
- `clear_request`, in, 1: one-cycle pulse requesting a back-page fill.
- `clear_value`, in, 8: fill byte, sampled on `clear_request`.
- `frame_end`, in, 1: one-cycle pulse from scan, issued after the last row is latched.
- `fetch_address`, in, ADDR_B_WIDTH: read address from `framebuffer_fetch`.
- `fetch_clk_enable`, in, 1: port-B enable from fetch.
- `ram_a_address`, out, ADDR_A_WIDTH+1: MSB is the page bit.
- `ram_a_data`, out, 8: write data to RAM.
- `ram_a_write_enable`, out, 1: RAM write strobe.
- `ram_a_clk_enable`, out, 1: RAM port-A enable.
- `ram_b_address`, out, ADDR_B_WIDTH+1: MSB is the page bit.
- `ram_b_clk_enable`, out, 1: RAM port-B enable.
- `front_page`, out, 1: page currently displayed.
- `swap_pending`, out, 1: a swap is accepted but not yet performed.
- `clear_busy`, out, 1: the clear engine is active.
- `swap_count`, out, SWAP_COUNT_WIDTH: completed swaps; wraps modulo 2^width.

## Operation
- The back page is always `~front_page`.
- Host writes are mapped to {back page, `host_address`}. The host always has priority on port A.
- Clear engine:
  - Holds an ADDR_A_WIDTH-bit pointer.
  - On each cycle with `host_write_enable`=0 and `clear_busy`=1, it writes `clear_value` to {back, pointer} and increments the pointer.
  - It finishes after writing the all-ones address.
- FSM states:
  - IDLE:
    - `clear_request` → CLEAR: pointer=0, latch `clear_value`.
    - `swap_request` → WAIT_FRAME.
    - If both arrive together: go to CLEAR and set the `swap_after_clear` flag.
  - CLEAR:
    - On the final write, go to WAIT_FRAME if `swap_after_clear` is set, else IDLE.
    - `swap_request` here sets `swap_after_clear`.
    - `clear_request` here is ignored; no restart.
  - WAIT_FRAME:
    - On `frame_end`: toggle `front_page`, increment `swap_count`, clear `swap_after_clear`, go to IDLE.
    - `clear_request` here is ignored.
- `swap_pending` = (state==WAIT_FRAME) | `swap_after_clear`.
- A `swap_request` while `swap_pending`=1 is ignored; the count is unchanged.
- A `frame_end` in the same cycle as the accepting `swap_request` does not swap; the swap waits for the next `frame_end`.
- Host writes continue during WAIT_FRAME and still target the old back page until the toggle.

## Timing
- Port A is registered: `ram_a_*` reflect the host/clear selection 1 cycle after the inputs.
- Port B is combinational: `ram_b_address` = {`front_page`, `fetch_address`} and `ram_b_clk_enable` = `fetch_clk_enable`. Fetch latency is unchanged.
- `front_page` toggles on the `clk_in` edge that samples `frame_end`=1 in WAIT_FRAME.
- A clear takes 2^ADDR_A_WIDTH cycles (4096) with no host traffic, and 4096 + N cycles when N cycles carry host writes.
- Reset values:
  - state IDLE; `front_page`=0, `swap_pending`=0, `clear_busy`=0, `swap_count`=0.
  - All `ram_a_*`=0.
  - Pointer=0, `swap_after_clear`=0.
- Asserting reset mid-clear or mid-wait aborts the operation immediately; no partial swap occurs.

## Structure
- Shared package holds the FSM state encoding (IDLE=0, CLEAR=1, WAIT_FRAME=2) and the page-size constants derived from ADDR_A_WIDTH/ADDR_B_WIDTH.
- The natural sub-module is `fb_clear_engine`: pointer, latched value, done flag, with inputs stall=`host_write_enable` and start.
- The FSM, swap logic and port muxing stay in the top module.
- `multimem` depth doubles (13-bit A address, 12-bit B address); the top-level `main` instantiates this block between `ctrl`, `fb_f` and `fb`.

## Test plan
- Reset, then host write addr 0x005 data 0xA5 → `ram_a_address`=0x1005, `ram_a_write_enable`=1 one cycle later; `ram_b_address`=0x000|fetch.
- `swap_request` at cycle 10, `frame_end` at cycle 50 → `front_page` 0→1 at cycle 51, `swap_count`=1; the next host write to 0x005 → `ram_a_address`=0x0005.
- `clear_request` with value 0x3C, no host traffic → 4096 writes of 0x3C to 0x1000–0x1FFF, `clear_busy` low after the 4096th.
- Clear with host writes on 100 interleaved cycles → host writes unaltered, clear completes in 4196 cycles, every back-page address written.
- `swap_request` and `clear_request` in the same cycle, then `frame_end` pulses mid-clear → no toggle until the first `frame_end` after the clear finishes; a second `swap_request` while pending leaves `swap_count`=1.
- Reset asserted during WAIT_FRAME → all outputs 0 immediately; a subsequent `frame_end` causes no toggle.

Source files
------------

// File: rtl/framebuffer_page_ctrl_pkg.sv
// rtl/framebuffer_page_ctrl_pkg.sv - shared FSM encoding and page geometry for the page-flip controller
package framebuffer_page_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CLEAR      = 2'd1,
    ST_WAIT_FRAME = 2'd2
  } fb_state_e;

  localparam int FB_ADDR_A_WIDTH     = 12;
  localparam int FB_ADDR_B_WIDTH     = 11;
  localparam int FB_SWAP_COUNT_WIDTH = 8;
  localparam int FB_PAGE_BYTES       = 1 << FB_ADDR_A_WIDTH;
  localparam int FB_PAGE_WORDS       = 1 << FB_ADDR_B_WIDTH;

endpackage

// File: rtl/fb_clear_engine.sv
// rtl/fb_clear_engine.sv - back-page fill pointer and latched fill byte, stalled by host writes
module fb_clear_engine
  import framebuffer_page_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_A_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [7:0]            i_value,
  input  logic                  i_run,
  input  logic                  i_stall,
  output logic                  o_write,
  output logic [ADDR_WIDTH-1:0] o_pointer,
  output logic [7:0]            o_value,
  output logic                  o_done
);

  logic [ADDR_WIDTH-1:0] r_pointer;
  logic [7:0]            r_value;

  assign o_write   = i_run & ~i_stall;
  // The pointer wraps back to zero on the final write, ready for the next fill.
  assign o_done    = o_write & (&r_pointer);
  assign o_pointer = r_pointer;
  assign o_value   = r_value;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_pointer <= '0;
      r_value   <= '0;
    end else if (i_start) begin
      r_pointer <= '0;
      r_value   <= i_value;
    end else if (o_write) begin
      r_pointer <= r_pointer + 1'b1;
    end
  end

endmodule

// File: rtl/framebuffer_page_ctrl.sv
// rtl/framebuffer_page_ctrl.sv - double-buffer page flip, background clear and port-A arbitration
module framebuffer_page_ctrl
  import framebuffer_page_ctrl_pkg::*;
#(
  parameter int ADDR_A_WIDTH     = FB_ADDR_A_WIDTH,
  parameter int ADDR_B_WIDTH     = FB_ADDR_B_WIDTH,
  parameter int SWAP_COUNT_WIDTH = FB_SWAP_COUNT_WIDTH
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic [ADDR_A_WIDTH-1:0]     host_address,
  input  logic [7:0]                  host_data,
  input  logic                        host_write_enable,
  input  logic                        host_clk_enable,
  input  logic                        swap_request,
  input  logic                        clear_request,
  input  logic [7:0]                  clear_value,
  input  logic                        frame_end,
  input  logic [ADDR_B_WIDTH-1:0]     fetch_address,
  input  logic                        fetch_clk_enable,
  output logic [ADDR_A_WIDTH:0]       ram_a_address,
  output logic [7:0]                  ram_a_data,
  output logic                        ram_a_write_enable,
  output logic                        ram_a_clk_enable,
  output logic [ADDR_B_WIDTH:0]       ram_b_address,
  output logic                        ram_b_clk_enable,
  output logic                        front_page,
  output logic                        swap_pending,
  output logic                        clear_busy,
  output logic [SWAP_COUNT_WIDTH-1:0] swap_count
);

  fb_state_e                   r_state, w_next_state;
  logic                        r_front;
  logic                        r_swap_after_clear, w_swap_after_clear_next;
  logic [SWAP_COUNT_WIDTH-1:0] r_count;
  logic                        w_toggle;
  logic                        w_start;
  logic                        w_back;
  logic                        w_clear_write;
  logic                        w_clear_done;
  logic [ADDR_A_WIDTH-1:0]     w_clear_pointer;
  logic [7:0]                  w_clear_value;
  logic [ADDR_A_WIDTH:0]       r_a_address;
  logic [7:0]                  r_a_data;
  logic                        r_a_write_enable;
  logic                        r_a_clk_enable;

  assign w_back = ~r_front;

  fb_clear_engine #(.ADDR_WIDTH(ADDR_A_WIDTH)) u_clear (
    .clk_in    (clk_in),
    .reset     (reset),
    .i_start   (w_start),
    .i_value   (clear_value),
    .i_run     (r_state == ST_CLEAR),
    .i_stall   (host_write_enable),
    .o_write   (w_clear_write),
    .o_pointer (w_clear_pointer),
    .o_value   (w_clear_value),
    .o_done    (w_clear_done)
  );

  always_comb begin
    w_next_state            = r_state;
    w_swap_after_clear_next = r_swap_after_clear;
    w_start                 = 1'b0;
    w_toggle                = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_request) begin
          w_next_state            = ST_CLEAR;
          w_start                 = 1'b1;
          w_swap_after_clear_next = swap_request;
        end else if (swap_request) begin
          w_next_state = ST_WAIT_FRAME;
        end
      end
      ST_CLEAR: begin
        if (swap_request) w_swap_after_clear_next = 1'b1;
        if (w_clear_done)
          w_next_state = w_swap_after_clear_next ? ST_WAIT_FRAME : ST_IDLE;
      end
      ST_WAIT_FRAME: begin
        if (frame_end) begin
          w_toggle                = 1'b1;
          w_swap_after_clear_next = 1'b0;
          w_next_state            = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state            <= ST_IDLE;
      r_swap_after_clear <= 1'b0;
      r_front            <= 1'b0;
      r_count            <= '0;
    end else begin
      r_state            <= w_next_state;
      r_swap_after_clear <= w_swap_after_clear_next;
      if (w_toggle) begin
        r_front <= ~r_front;
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Host owns port A whenever it writes; the clear engine only fills the gaps.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_a_address      <= '0;
      r_a_data         <= '0;
      r_a_write_enable <= 1'b0;
      r_a_clk_enable   <= 1'b0;
    end else if (host_write_enable) begin
      r_a_address      <= {w_back, host_address};
      r_a_data         <= host_data;
      r_a_write_enable <= 1'b1;
      r_a_clk_enable   <= host_clk_enable;
    end else if (w_clear_write) begin
      r_a_address      <= {w_back, w_clear_pointer};
      r_a_data         <= w_clear_value;
      r_a_write_enable <= 1'b1;
      r_a_clk_enable   <= 1'b1;
    end else begin
      r_a_address      <= {w_back, host_address};
      r_a_data         <= host_data;
      r_a_write_enable <= 1'b0;
      r_a_clk_enable   <= host_clk_enable;
    end
  end

  assign ram_a_address      = r_a_address;
  assign ram_a_data         = r_a_data;
  assign ram_a_write_enable = r_a_write_enable;
  assign ram_a_clk_enable   = r_a_clk_enable;
  assign ram_b_address      = {r_front, fetch_address};
  assign ram_b_clk_enable   = fetch_clk_enable;
  assign front_page         = r_front;
  assign swap_pending       = (r_state == ST_WAIT_FRAME) | r_swap_after_clear;
  assign clear_busy         = (r_state == ST_CLEAR);
  assign swap_count         = r_count;

endmodule
